// File: rtl/rv_soc_top.sv
// rv_soc_top: minimal single-cycle RV32I SoC (core + instruction ROM + optional data RAM)
// Ports:
//   clk  in  1  single clock, all state updates on the rising edge
//   rst  in  1  synchronous active-high reset
// Build option: define RV_SOC_DATA_RAM_EN to instantiate the data RAM; without it
// loads return 0 and stores are dropped.
// Hierarchy: rv_core_ins.regs_ins.regs[0:31] (register file), rom_ins.rom_mem[] (program).

// rv_regfile: 32x32 register file with two combinational reads and one clocked write.
// Ports: clk, rst, rs1/rs2 read indices, rd/we/wdata write port, rdata1/rdata2 read data.
module rv_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && rd != 5'd0) begin
            regs[rd] <= wdata;
        end
    end

    assign rdata1 = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rdata2 = (rs2 == 5'd0) ? '0 : regs[rs2];
endmodule

// rv_rom: instruction ROM, combinational word read. Ports: idx word index, data word.
// Unloaded words hold ADDI x0,x0,0 so a stray fetch behaves as a NOP.
module rv_rom #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic [AW-1:0] idx,
    output logic [31:0]   data
);
    logic [31:0] rom_mem [0:DEPTH-1] = '{default: 32'h0000_0013};

    assign data = rom_mem[idx];
endmodule

// rv_core: single-cycle RV32I datapath.
// Ports: clk, rst, instr fetched word, imem_idx fetch word index, dmem_idx data word index,
// dmem_wdata/dmem_be/dmem_we store port, dmem_rdata load word.
module rv_core #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          ROM_AW   = 12,
    parameter int          RAM_AW   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    output logic [ROM_AW-1:0] imem_idx,
    output logic [RAM_AW-1:0] dmem_idx,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    output logic              dmem_we,
    input  logic [31:0]       dmem_rdata
);
    logic [31:0] pc, pc_next, pc_plus4;
    logic [31:0] rs1_val, rs2_val, rd_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_b, alu_res, sra_res, addr, load_val, shifted;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op;
    logic        br_eq, br_lt, br_ltu, br_cond, br_taken, rf_we;
    logic        unused_addr;

    assign opcode    = instr[6:0];
    assign f3        = instr[14:12];
    assign is_lui    = opcode == 7'b0110111;
    assign is_auipc  = opcode == 7'b0010111;
    assign is_jal    = opcode == 7'b1101111;
    assign is_jalr   = opcode == 7'b1100111;
    assign is_branch = opcode == 7'b1100011;
    assign is_load   = opcode == 7'b0000011;
    assign is_store  = opcode == 7'b0100011;
    assign is_opimm  = opcode == 7'b0010011;
    assign is_op     = opcode == 7'b0110011;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    rv_regfile regs_ins (
        .clk    (clk),
        .rst    (rst),
        .rs1    (instr[19:15]),
        .rs2    (instr[24:20]),
        .rd     (instr[11:7]),
        .we     (rf_we),
        .wdata  (rd_val),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val)
    );

    assign alu_b = is_op ? rs2_val : imm_i;
    // Kept as its own signal so the arithmetic shift is not widened to unsigned by a mux.
    assign sra_res = $signed(rs1_val) >>> alu_b[4:0];

    always_comb begin
        case (f3)
            3'b000:  alu_res = (is_op && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_res = rs1_val << alu_b[4:0];
            3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_res = {31'b0, rs1_val < alu_b};
            3'b100:  alu_res = rs1_val ^ alu_b;
            3'b101:  alu_res = instr[30] ? sra_res : rs1_val >> alu_b[4:0];
            3'b110:  alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    // Branch compare: f3[2:1] picks eq/lt/ltu, f3[0] inverts; f3=01x is undefined and never taken.
    assign br_eq    = rs1_val == rs2_val;
    assign br_lt    = $signed(rs1_val) < $signed(rs2_val);
    assign br_ltu   = rs1_val < rs2_val;
    assign br_cond  = f3[2] ? (f3[1] ? br_ltu : br_lt) : br_eq;
    assign br_taken = is_branch && (f3[2:1] != 2'b01) && (br_cond ^ f3[0]);

    assign addr        = rs1_val + (is_store ? imm_s : imm_i);
    assign dmem_idx    = addr[RAM_AW+1:2];
    assign unused_addr = ^addr[31:RAM_AW+2];

    // Misaligned loads only look at the lane bits of the address.
    assign shifted = dmem_rdata >> {addr[1:0], 3'b000};
    assign ld_byte = shifted[7:0];
    assign ld_half = addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (f3)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'b0, ld_byte};
            3'b101:  load_val = {16'b0, ld_half};
            default: load_val = dmem_rdata;
        endcase
    end

    assign dmem_we    = is_store && !rst;
    assign dmem_be    = !is_store     ? 4'b0000 :
                        f3 == 3'b000  ? 4'b0001 << addr[1:0] :
                        f3 == 3'b001  ? (addr[1] ? 4'b1100 : 4'b0011) :
                        f3 == 3'b010  ? 4'b1111 : 4'b0000;
    assign dmem_wdata = f3[1:0] == 2'b00 ? {4{rs2_val[7:0]}} :
                        f3[1:0] == 2'b01 ? {2{rs2_val[15:0]}} : rs2_val;

    assign pc_plus4 = pc + 32'd4;
    assign rd_val   = is_lui              ? imm_u :
                      is_auipc            ? pc + imm_u :
                      (is_jal || is_jalr) ? pc_plus4 :
                      is_load             ? load_val : alu_res;
    // A reset edge aborts the instruction in flight, so no register write then.
    assign rf_we    = (is_lui || is_auipc || is_jal || is_jalr || is_load || is_opimm || is_op) && !rst;

    assign pc_next  = is_jal   ? pc + imm_j :
                      is_jalr  ? (rs1_val + imm_i) & ~32'h1 :
                      br_taken ? pc + imm_b : pc_plus4;

    always_ff @(posedge clk) begin
        if (rst) pc <= RESET_PC;
        else     pc <= pc_next;
    end

    assign imem_idx = pc[ROM_AW+1:2];
endmodule

module rv_soc_top #(
    parameter int          ROM_DEPTH = 4096,
    parameter int          RAM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input logic clk,
    input logic rst
);
    localparam int ROM_AW = $clog2(ROM_DEPTH);
    localparam int RAM_AW = $clog2(RAM_DEPTH);

    logic [ROM_AW-1:0] imem_idx;
    logic [RAM_AW-1:0] dmem_idx;
    logic [31:0]       instr, dmem_wdata, dmem_rdata;
    logic [3:0]        dmem_be;
    logic              dmem_we;

    rv_core #(.RESET_PC(RESET_PC), .ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) rv_core_ins (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .imem_idx   (imem_idx),
        .dmem_idx   (dmem_idx),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata)
    );

    rv_rom #(.DEPTH(ROM_DEPTH), .AW(ROM_AW)) rom_ins (
        .idx  (imem_idx),
        .data (instr)
    );

`ifdef RV_SOC_DATA_RAM_EN
    logic [31:0] ram [0:RAM_DEPTH-1] = '{default: 32'h0};

    // RAM has no reset: its contents survive a core reset.
    always_ff @(posedge clk) begin
        if (dmem_we)
            for (int i = 0; i < 4; i++)
                if (dmem_be[i]) ram[dmem_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
    end

    assign dmem_rdata = ram[dmem_idx];
`else
    logic unused_dmem;

    assign dmem_rdata  = '0;
    assign unused_dmem = ^{dmem_idx, dmem_wdata, dmem_be, dmem_we};
`endif
endmodule

// File: tb/tb_rv_soc_top.sv
// tb_rv_soc_top: directed scoreboard bench for rv_soc_top
module tb_rv_soc_top;
    localparam int ROM_DEPTH = 4096;
    localparam logic [6:0] OPI = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] LOAD = 7'b0000011, JALR = 7'b1100111;
`ifdef RV_SOC_DATA_RAM_EN
    localparam bit RAM_EN = 1'b1;
`else
    localparam bit RAM_EN = 1'b0;
`endif

    typedef struct {
        string       tag;
        int          r;
        logic [31:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad = 0;
    exp_t        sbq[$];
    logic [31:0] prog[$];

    rv_soc_top dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] observe(int r);
        logic [4:0] idx;
        idx = r[4:0];
        if (r < 0) return dut.rv_core_ins.pc;
        return dut.rv_core_ins.regs_ins.regs[idx];
    endfunction

    task automatic expect_val(input string tag, input int r, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.r   = r;
        e.v   = v;
        sbq.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] o;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            o = observe(e.r);
            total++;
            assert (o === e.v) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.v);
            end
        end
    endtask

    task automatic load_rom();
        for (int i = 0; i < ROM_DEPTH; i++) dut.rom_ins.rom_mem[i] = 32'h0000_0013;
        for (int i = 0; i < prog.size(); i++) dut.rom_ins.rom_mem[i] = prog[i];
    endtask

    task automatic start();
        rst = 1'b1;
        load_rom();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        #1;
        // reset: x27 must stay 0 while rst holds, then be written one edge after release
        prog = {enc_i(12'd1, 5'd0, 3'd0, 5'd27, OPI)};
        load_rom();
        for (int k = 0; k < 2; k++) begin
            step();
            expect_val("rst_pc", -1, 32'h0);
            expect_val("rst_x27", 27, 32'h0);
            check_all();
        end
        rst = 1'b0;
        step();
        expect_val("rel_x27", 27, 32'h1);
        expect_val("rel_pc", -1, 32'h4);
        check_all();

        // ALU
        prog = {enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, OPI),
                enc_i(12'd28, 5'd1, 3'b101, 5'd2, OPI),
                enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd3),
                enc_r(7'h00, 5'd1, 5'd0, 3'b011, 5'd4),
                enc_u(20'h12345, 5'd7, LUI),
                enc_i(12'h678, 5'd7, 3'b000, 5'd7, OPI),
                enc_r(7'h20, 5'd7, 5'd0, 3'b000, 5'd8),
                enc_r(7'h00, 5'd0, 5'd8, 3'b010, 5'd9),
                enc_u(20'h00001, 5'd11, AUIPC),
                enc_i(12'h404, 5'd8, 3'b101, 5'd12, OPI),
                enc_i(12'h0F0, 5'd7, 3'b111, 5'd13, OPI),
                enc_r(7'h00, 5'd2, 5'd2, 3'b001, 5'd14)};
        start();
        repeat (12) step();
        expect_val("addi_neg", 1, 32'hFFFF_FFFF);
        expect_val("srli", 2, 32'h0000_000F);
        expect_val("sra", 3, 32'hFFFF_FFFF);
        expect_val("sltu", 4, 32'h1);
        expect_val("lui_addi", 7, 32'h1234_5678);
        expect_val("sub", 8, 32'hEDCB_A988);
        expect_val("slt", 9, 32'h1);
        expect_val("auipc", 11, 32'h0000_1020);
        expect_val("srai", 12, 32'hFEDC_BA98);
        expect_val("andi", 13, 32'h0000_0070);
        expect_val("sll", 14, 32'h0007_8000);
        expect_val("alu_pc", -1, 32'h30);
        check_all();

        // control flow
        prog = {enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, OPI),
                enc_b(13'd8, 5'd0, 5'd0, 3'b000),
                enc_i(12'd99, 5'd0, 3'b000, 5'd1, OPI),
                enc_b(13'd8, 5'd0, 5'd1, 3'b110),
                enc_j(21'd12, 5'd5),
                enc_i(12'd1, 5'd2, 3'b000, 5'd2, OPI),
                enc_b(13'h40, 5'd0, 5'd1, 3'b100),
                enc_i(12'd1, 5'd5, 3'b000, 5'd6, JALR)};
        start();
        step(); expect_val("ctl_pc1", -1, 32'h04); check_all();
        step(); expect_val("beq_taken", -1, 32'h0C); check_all();
        step(); expect_val("bltu_not", -1, 32'h10); expect_val("beq_skip", 1, 32'hFFFF_FFFF); check_all();
        step(); expect_val("jal_pc", -1, 32'h1C); expect_val("jal_link", 5, 32'h14); check_all();
        step(); expect_val("jalr_pc", -1, 32'h14); expect_val("jalr_link", 6, 32'h20); check_all();
        step(); expect_val("loop_x2", 2, 32'h1); expect_val("ctl_pc6", -1, 32'h18); check_all();
        step(); expect_val("blt_taken", -1, 32'h58); check_all();

        // data memory
        prog = {enc_u(20'h80FF8, 5'd1, LUI),
                enc_i(12'hF01, 5'd1, 3'b000, 5'd1, OPI),
                enc_i(12'h100, 5'd0, 3'b000, 5'd2, OPI),
                enc_s(12'd0, 5'd1, 5'd2, 3'b010),
                enc_i(12'd3, 5'd2, 3'b000, 5'd3, LOAD),
                enc_i(12'd3, 5'd2, 3'b100, 5'd4, LOAD),
                enc_i(12'd2, 5'd2, 3'b001, 5'd5, LOAD),
                enc_s(12'd1, 5'd0, 5'd2, 3'b000),
                enc_i(12'd0, 5'd2, 3'b010, 5'd6, LOAD),
                enc_i(12'd0, 5'd2, 3'b101, 5'd7, LOAD),
                enc_s(12'd2, 5'd1, 5'd2, 3'b001),
                enc_i(12'd0, 5'd2, 3'b010, 5'd8, LOAD)};
        start();
        repeat (12) step();
        expect_val("st_val", 1, 32'h80FF_7F01);
        expect_val("lb", 3, RAM_EN ? 32'hFFFF_FF80 : 32'h0);
        expect_val("lbu", 4, RAM_EN ? 32'h0000_0080 : 32'h0);
        expect_val("lh", 5, RAM_EN ? 32'hFFFF_80FF : 32'h0);
        expect_val("sb_lw", 6, RAM_EN ? 32'h80FF_0001 : 32'h0);
        expect_val("lhu", 7, RAM_EN ? 32'h0000_0001 : 32'h0);
        expect_val("sh_lw", 8, RAM_EN ? 32'h7F01_0001 : 32'h0);
        check_all();
        prog = {enc_i(12'h100, 5'd0, 3'b010, 5'd9, LOAD)};
        start();
        step();
        expect_val("ram_keep", 9, RAM_EN ? 32'h7F01_0001 : 32'h0);
        check_all();

        // x0, NOP-class opcodes, ROM wrap
        prog = {enc_i(12'd5, 5'd0, 3'b000, 5'd0, OPI),
                32'h0000_0073,
                32'h0000_000F,
                32'hFFFF_FFFF,
                enc_u(20'h00004, 5'd13, LUI),
                enc_i(12'd0, 5'd13, 3'b000, 5'd0, JALR)};
        start();
        step(); expect_val("x0_pc", -1, 32'h04); expect_val("x0_zero", 0, 32'h0); check_all();
        step(); expect_val("ecall_pc", -1, 32'h08); check_all();
        step(); expect_val("fence_pc", -1, 32'h0C); check_all();
        step(); expect_val("unk_pc", -1, 32'h10); expect_val("unk_x31", 31, 32'h0); check_all();
        step(); expect_val("lui_4000", 13, 32'h4000); check_all();
        step(); expect_val("jalr_far", -1, 32'h4000); check_all();
        step(); expect_val("wrap_pc", -1, 32'h4004); expect_val("wrap_x0", 0, 32'h0); check_all();

        // completion flags
        prog = {enc_i(12'd1, 5'd0, 3'b000, 5'd27, OPI),
                enc_i(12'd1, 5'd0, 3'b000, 5'd26, OPI)};
        start();
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            step();
            seen = observe(26) === 32'h1;
        end
        total++;
        assert (seen === 1'b1) else begin
            bad++;
            $error("FAIL x26_rise observed=%b expected=%b", seen, 1'b1);
        end
        #40;
        expect_val("pass_x27", 27, 32'h1);
        check_all();
        rst = 1'b1;
        step();
        expect_val("clr_x26", 26, 32'h0);
        expect_val("clr_x27", 27, 32'h0);
        expect_val("clr_pc", -1, 32'h0);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
